// File: rtl/uart_pkg.sv
// Shared definitions for the UART link: parity modes, FSM state types and
// the parity helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Data narrower than 8 bits is zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. A push while full is accepted only
// when a pop happens in the same cycle.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_link.sv
// Full-duplex UART: handshaked transmitter plus a receiver with start-bit
// glitch rejection, parity/framing checks and a FWFT receive FIFO.
import uart_pkg::*;

module uart_link #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);

  localparam int             CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [2:0]     LAST_IDX = 3'(DATA_W - 1);
  localparam logic [1:0]     PMODE    = 2'(PARITY);
  localparam bit             HAS_PAR  = (PMODE != PAR_NONE);

  tx_state_t         tx_state, tx_state_n;
  logic [CW-1:0]     tx_cnt, tx_cnt_n;
  logic [2:0]        tx_idx, tx_idx_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              tx_par, tx_par_n;

  rx_state_t         rx_state, rx_state_n;
  logic [CW-1:0]     rx_cnt, rx_cnt_n;
  logic [2:0]        rx_idx, rx_idx_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic              rx_par, rx_par_n;
  logic              rx_meta, rx_sync, rx_prev;
  logic              frame_err_n, parity_err_n, push_n, push_q;

  logic              fifo_full, fifo_empty, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = (tx_cnt == BIT_END) ? '0 : tx_cnt + CW'(1);
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx         = 1'b1;
    tx_ready   = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        tx_cnt_n = '0;
        tx_idx_n = '0;
        if (tx_valid) begin
          tx_shift_n = tx_data;
          tx_par_n   = parity_bit(8'(tx_data), PMODE);
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_cnt == BIT_END) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx = tx_shift[0];
        if (tx_cnt == BIT_END) begin
          tx_shift_n = tx_shift >> 1;
          tx_idx_n   = tx_idx + 3'd1;
          if (tx_idx == LAST_IDX) tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: begin
        tx = tx_par;
        if (tx_cnt == BIT_END) tx_state_n = TX_STOP;
      end
      TX_STOP: begin
        if (tx_cnt == BIT_END) tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Receiver: every sample after the start-bit check lands one bit period later, i.e. mid-bit.
  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt + CW'(1);
    rx_idx_n     = rx_idx;
    rx_shift_n   = rx_shift;
    rx_par_n     = rx_par;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
    push_n       = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[DATA_W-1:1]};
          rx_idx_n   = rx_idx + 3'd1;
          if (rx_idx == LAST_IDX) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_par_n   = rx_sync;
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (!rx_sync)
            frame_err_n = 1'b1;
          else if (HAS_PAR && (rx_par != parity_bit(8'(rx_shift), PMODE)))
            parity_err_n = 1'b1;
          else
            push_n = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_idx        <= '0;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      push_q        <= 1'b0;
    end else begin
      tx_state      <= tx_state_n;
      tx_cnt        <= tx_cnt_n;
      tx_idx        <= tx_idx_n;
      rx_state      <= rx_state_n;
      rx_cnt        <= rx_cnt_n;
      rx_idx        <= rx_idx_n;
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      rx_frame_err  <= frame_err_n;
      rx_parity_err <= parity_err_n;
      push_q        <= push_n;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_n;
    tx_par   <= tx_par_n;
    rx_shift <= rx_shift_n;
    rx_par   <= rx_par_n;
  end

  // rx_shift stays stable in RX_IDLE, so it doubles as the FIFO write data one cycle after the stop sample.
  assign pop        = rx_ready && !fifo_empty;
  assign rx_valid   = (fifo_count != '0);
  assign rx_overrun = push_q && fifo_full && !pop;

  uart_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (rx_shift),
    .pop       (pop),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
